// File: rtl/cmpx_mac_pkg.sv
// Shared types and helpers for the accumulating complex multiplier (cmpx_mac).
package cmpx_mac_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, DONE} state_e;

  localparam logic [1:0] PH_XZ = 2'd0;
  localparam logic [1:0] PH_YW = 2'd1;
  localparam logic [1:0] PH_XW = 2'd2;
  localparam logic [1:0] PH_YZ = 2'd3;

  localparam int DEF_W     = 4;
  localparam int DEF_ACC_W = 2*DEF_W + 2;

  typedef struct packed {
    logic        clip;
    logic [63:0] val;
  } fit_t;

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
    logic signed [63:0] t;
    t = v << (64 - w);
    return t >>> (64 - w);
  endfunction

  // Clamp a 64-bit sum to a signed w-bit range when sat is set; caller truncates otherwise.
  function automatic fit_t fit_acc(input logic signed [63:0] v, input int w, input logic sat);
    logic signed [63:0] hi, lo;
    fit_t r;
    hi     = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo     = -hi - 64'sd1;
    r.clip = 1'b0;
    r.val  = v;
    if (sat && v > hi) begin
      r.val  = hi;
      r.clip = 1'b1;
    end else if (sat && v < lo) begin
      r.val  = lo;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_signed.sv
// W-cycle shift-add signed multiplier: multiplies magnitudes, then negates if signs differ.
module seq_mult_signed #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] p
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   a_mag, b_mag, mplier;
  logic [2*W-1:0] mcand, prod;
  logic [CW-1:0]  cnt;
  logic           neg;

  // -2^(W-1) maps to an unsigned magnitude of 2^(W-1), which still fits W bits.
  assign a_mag = a[W-1] ? (~a + W'(1)) : a;
  assign b_mag = b[W-1] ? (~b + W'(1)) : b;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else if (start) begin
      mcand  <= {{W{1'b0}}, a_mag};
      mplier <= b_mag;
      prod   <= '0;
      cnt    <= CW'(W);
      neg    <= a[W-1] ^ b[W-1];
    end else if (cnt != '0) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

  // Flags the cycle whose closing edge performs the final step.
  assign done = (cnt == CW'(1));
  assign p    = neg ? (~prod + (2*W)'(1)) : prod;

endmodule

// File: rtl/cmpx_mac.sv
// Accumulating complex MAC: re += xz - yw, im += xw + yz, one shared sequential multiplier.
// Optional macro CMPX_MAC_SAT_EN: saturating accumulation with sticky ovf.
module cmpx_mac
  import cmpx_mac_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = 2*W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic [2*W-1:0]   a,
  input  logic [2*W-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_re,
  output logic [ACC_W-1:0] acc_im,
  output logic             ovf
);
  if (W < 2) begin : g_bad_w
    $error("cmpx_mac: W must be >= 2");
  end
  if (ACC_W < 2*W + 1) begin : g_bad_acc
    $error("cmpx_mac: ACC_W must be >= 2*W+1");
  end
  if (ACC_W > 62) begin : g_big_acc
    $error("cmpx_mac: ACC_W must be <= 62");
  end

`ifdef CMPX_MAC_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  state_e         state;
  logic [1:0]     phase, sel;
  logic [2*W-1:0] a_q, b_q;
  logic           clr_q;
  logic [W-1:0]   x, y, z, w, m_a, m_b;
  logic           m_start, m_done;
  logic [2*W-1:0] m_p;
  logic           tgt_im, sub;
  logic signed [63:0] cur, pr, sum;
  fit_t           fit;
  logic           unused_hi;

  assign x = a_q[2*W-1:W];
  assign y = a_q[W-1:0];
  assign z = b_q[2*W-1:W];
  assign w = b_q[W-1:0];

  // The multiplier loads on the edge leaving LOAD/ACC, so pick the upcoming phase.
  assign sel     = (state == ACC) ? phase + 2'd1 : PH_XZ;
  assign m_start = (state == LOAD) || (state == ACC && phase != PH_YZ);

  always_comb begin
    m_a = x;
    m_b = z;
    case (sel)
      PH_XZ: begin m_a = x; m_b = z; end
      PH_YW: begin m_a = y; m_b = w; end
      PH_XW: begin m_a = x; m_b = w; end
      default: begin m_a = y; m_b = z; end
    endcase
  end

  seq_mult_signed #(.W(W)) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (m_start),
    .a     (m_a),
    .b     (m_b),
    .done  (m_done),
    .p     (m_p)
  );

  assign tgt_im    = phase[1];
  assign sub       = (phase == PH_YW);
  assign cur       = sext(64'(tgt_im ? acc_im : acc_re), ACC_W);
  assign pr        = sext(64'(m_p), 2*W);
  assign sum       = sub ? cur - pr : cur + pr;
  assign fit       = fit_acc(sum, ACC_W, SAT);
  assign unused_hi = ^fit.val[63:ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= PH_XZ;
      a_q    <= '0;
      b_q    <= '0;
      clr_q  <= 1'b0;
      acc_re <= '0;
      acc_im <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          clr_q <= clr;
          state <= LOAD;
        end
        LOAD: begin
          if (clr_q) begin
            acc_re <= '0;
            acc_im <= '0;
            ovf    <= 1'b0;
          end
          phase <= PH_XZ;
          busy  <= 1'b1;
          state <= MUL;
        end
        MUL: if (m_done) state <= ACC;
        ACC: begin
          if (tgt_im) acc_im <= fit.val[ACC_W-1:0];
          else        acc_re <= fit.val[ACC_W-1:0];
          if (fit.clip) ovf <= 1'b1;
          if (phase == PH_YZ) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            phase <= phase + 2'd1;
            state <= MUL;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmpx_mac.sv
// Directed bench for cmpx_mac: scoreboard of expected accumulator states, checked at done.
module tb_cmpx_mac;
  localparam int W     = 4;
  localparam int ACC_W = 10;
  localparam int LIM   = 2**(ACC_W-1);

  logic             clk = 1'b0;
  logic             rst, start, clr;
  logic [2*W-1:0]   a, b;
  logic             busy, done, ovf;
  logic [ACC_W-1:0] acc_re, acc_im;

  always #5 clk = ~clk;

  cmpx_mac #(.W(W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .a(a), .b(b),
    .busy(busy), .done(done), .acc_re(acc_re), .acc_im(acc_im), .ovf(ovf)
  );

  typedef struct { int re; int im; bit ovf; } exp_t;
  exp_t sbq[$];
  int   m_re, m_im;
  bit   m_ovf;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] pk(input int hi, input int lo);
    logic [W-1:0] h, l;
    h = hi[W-1:0];
    l = lo[W-1:0];
    return {h, l};
  endfunction

  function automatic int acc_step(input int cur, input int p);
    int s;
    s = cur + p;
`ifdef CMPX_MAC_SAT_EN
    if (s > LIM - 1) begin s = LIM - 1; m_ovf = 1'b1; end
    else if (s < -LIM) begin s = -LIM; m_ovf = 1'b1; end
`else
    s = s & (2*LIM - 1);
    if (s >= LIM) s -= 2*LIM;
`endif
    return s;
  endfunction

  task automatic model(input int x, input int y, input int z, input int w, input bit c);
    exp_t e;
    if (c) begin m_re = 0; m_im = 0; m_ovf = 1'b0; end
    m_re = acc_step(m_re, x*z);
    m_re = acc_step(m_re, -(y*w));
    m_im = acc_step(m_im, x*w);
    m_im = acc_step(m_im, y*z);
    e = '{m_re, m_im, m_ovf};
    sbq.push_back(e);
  endtask

  // glitch: extra start pulses at cycles 5 and 10; rst_at>0: reset during that cycle.
  task automatic run_op(input int x, input int y, input int z, input int w, input bit c,
                        input bit glitch, input int rst_at);
    exp_t e;
    int   cyc;
    bit   got, saw;
    a = pk(x, y); b = pk(z, w); clr = c; start = 1'b1;
    model(x, y, z, w, c);
    @(negedge clk);
    start = 1'b0;
    a = 2*W'($urandom); b = 2*W'($urandom); clr = 1'($urandom);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = glitch && (cyc == 4 || cyc == 9);
      if (glitch && start) begin a = pk(7, 7); b = pk(7, 7); clr = 1'b1; end
      if (rst_at == cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_re", $signed(acc_re), 0);
        check("rst_im", $signed(acc_im), 0);
        check("rst_ovf", ovf, 0);
        m_re = 0; m_im = 0; m_ovf = 1'b0;
        sbq.delete();
        saw = 1'b0;
        repeat (25) begin @(negedge clk); saw |= done; end
        check("rst_no_done", saw, 0);
        return;
      end
      if (done) begin
        got = 1'b1;
        check("done_cycle", cyc, 21);
        check("busy_at_done", busy, 0);
        if (sbq.size() == 0) check("extra_done", 1, 0);
        else begin
          e = sbq.pop_front();
          check("acc_re", $signed(acc_re), e.re);
          check("acc_im", $signed(acc_im), e.im);
          check("ovf", ovf, e.ovf);
        end
      end else if (cyc <= 20) begin
        if (!busy) check("busy_mid", busy, 1);
      end
    end
    if (!got) check("done_timeout", 0, 1);
    start = 1'b0;
    saw = 1'b0;
    repeat (3) begin @(negedge clk); saw |= done; end
    check("single_done", saw, 0);
    check("hold_re", $signed(acc_re), m_re);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clr = 1'b0; a = '0; b = '0;
    m_re = 0; m_im = 0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_re", $signed(acc_re), 0);
    check("reset_im", $signed(acc_im), 0);
    check("reset_ovf", ovf, 0);

    // start together with rst must be dropped
    start = 1'b1; a = pk(1, 1); b = pk(1, 1); clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_beats_start", busy, 0);

    run_op(2, 3, 2, 1, 1'b1, 1'b0, 0);
    check("lit_op1_re", $signed(acc_re), 1);
    check("lit_op1_im", $signed(acc_im), 8);
    run_op(2, 2, 1, 2, 1'b0, 1'b0, 0);
    check("lit_op2_im", $signed(acc_im), 14);
    run_op(1, 0, 1, 3, 1'b1, 1'b0, 0);

    run_op(-8, -8, -8, 0, 1'b1, 1'b0, 0);
    check("lit_neg_re", $signed(acc_re), 64);
    check("lit_neg_im", $signed(acc_im), 64);
    repeat (7) run_op(-8, -8, -8, 0, 1'b0, 1'b0, 0);
`ifdef CMPX_MAC_SAT_EN
    check("lit_sat_re", $signed(acc_re), 511);
    check("lit_sat_ovf", ovf, 1);
`else
    check("lit_wrap_re", $signed(acc_re), -512);
    check("lit_wrap_ovf", ovf, 0);
`endif
    run_op(1, 0, 1, 3, 1'b1, 1'b0, 0);
    check("clr_ovf", ovf, 0);

    run_op(2, 3, 2, 1, 1'b1, 1'b1, 0);
    check("lit_glitch_im", $signed(acc_im), 8);

    run_op(3, 3, 3, 3, 1'b0, 1'b0, 12);
    run_op(2, 2, 1, 2, 1'b0, 1'b0, 0);
    check("lit_post_rst_re", $signed(acc_re), -2);
    check("lit_post_rst_im", $signed(acc_im), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
